// File: rtl/em_pkg.sv
// Shared definitions for the EX/MEM pipeline stage: default widths, control-bit
// indices and the packed EX/MEM bundle type.
package em_pkg;

  localparam int unsigned EM_CTRL_W = 7;
  localparam int unsigned EM_DATA_W = 16;
  localparam int unsigned EM_ADDR_W = 16;
  localparam int unsigned EM_RNUM_W = 3;
  localparam int unsigned EM_CNT_W  = 16;

  // Control-bit positions within the ctrl bundle
  localparam int unsigned WB_BIT = 0;
  localparam int unsigned MEM_RD = 1;
  localparam int unsigned MEM_WR = 2;

  typedef struct packed {
    logic [EM_CTRL_W-1:0] ctrl;
    logic [EM_DATA_W-1:0] result;
    logic [EM_ADDR_W-1:0] addr;
    logic [EM_RNUM_W-1:0] rnum;
    logic [EM_DATA_W-1:0] rval;
    logic [EM_DATA_W-1:0] sp;
  } em_bundle_t;

endpackage

// File: rtl/em_skid_slot.sv
// One-entry skid slot for the EX/MEM stage: a bundle register plus valid bit.
// Write has priority over read so a move-out and a new fill can share a cycle.
module em_skid_slot
  import em_pkg::*;
#(
  parameter int unsigned W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush_i,
  input  logic         wr_i,
  input  logic         rd_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // Next-state for the slot contents and occupancy
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (wr_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (rd_i) begin
      valid_d = 1'b0;
    end
  end

  // Slot register, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/em_pipe_stage.sv
// EX/MEM pipeline stage with valid/ready handshake, stall, flush, forwarding tap
// and saturating bubble counter. Define EM_SKID_BUFFER_EN to add a one-entry skid
// slot, which removes the out_ready -> in_ready combinational path.
module em_pipe_stage
  import em_pkg::*;
#(
  parameter int unsigned CTRL_W = EM_CTRL_W,
  parameter int unsigned DATA_W = EM_DATA_W,
  parameter int unsigned ADDR_W = EM_ADDR_W,
  parameter int unsigned RNUM_W = EM_RNUM_W,
  parameter int unsigned WB_BIT = em_pkg::WB_BIT,
  parameter int unsigned CNT_W  = EM_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              stall,
  input  logic              flush,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] result_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [RNUM_W-1:0] rnum_in,
  input  logic [DATA_W-1:0] rval_in,
  input  logic [DATA_W-1:0] sp_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [DATA_W-1:0] result_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic [RNUM_W-1:0] rnum_out,
  output logic [DATA_W-1:0] rval_out,
  output logic [DATA_W-1:0] sp_out,
  output logic              fwd_valid,
  output logic [RNUM_W-1:0] fwd_rnum,
  output logic [DATA_W-1:0] fwd_value,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam int unsigned BW = CTRL_W + ADDR_W + RNUM_W + 3 * DATA_W;

  logic [BW-1:0]     in_bus;
  logic [BW-1:0]     main_q, main_d;
  logic              main_valid_q, main_valid_d;
  logic [CNT_W-1:0]  bubble_q, bubble_d;
  logic [CTRL_W-1:0] ctrl_r;
  logic              accept;

  assign in_bus = {ctrl_in, result_in, addr_in, rnum_in, rval_in, sp_in};
  assign accept = in_valid & in_ready;

`ifdef EM_SKID_BUFFER_EN
  logic          skid_valid, skid_wr, skid_rd;
  logic [BW-1:0] skid_data;

  em_skid_slot #(
    .W (BW)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .flush_i (flush),
    .wr_i    (skid_wr),
    .rd_i    (skid_rd),
    .data_i  (in_bus),
    .valid_o (skid_valid),
    .data_o  (skid_data)
  );

  assign in_ready = !flush && !stall && !skid_valid;

  // Main register refills from the skid slot first so order is preserved
  always_comb begin
    main_valid_d = main_valid_q;
    main_d       = main_q;
    skid_wr      = 1'b0;
    skid_rd      = 1'b0;
    if (flush) begin
      main_valid_d = 1'b0;
    end else if (!main_valid_q || out_ready) begin
      if (skid_valid) begin
        main_d       = skid_data;
        main_valid_d = 1'b1;
        skid_rd      = 1'b1;
        skid_wr      = accept;
      end else if (accept) begin
        main_d       = in_bus;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_wr = 1'b1;
    end
  end
`else
  assign in_ready = !flush && !stall && (!main_valid_q || out_ready);

  // Load on accept, empty on drain, kill on flush
  always_comb begin
    main_valid_d = main_valid_q;
    main_d       = main_q;
    if (flush) begin
      main_valid_d = 1'b0;
    end else if (accept) begin
      main_d       = in_bus;
      main_valid_d = 1'b1;
    end else if (out_ready) begin
      main_valid_d = 1'b0;
    end
  end
`endif

  // Count empty-output cycles, saturating at all-ones
  always_comb begin
    bubble_d = bubble_q;
    if (!main_valid_q && (bubble_q != {CNT_W{1'b1}})) begin
      bubble_d = bubble_q + CNT_W'(1);
    end
  end

  // Stage registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      main_valid_q <= 1'b0;
      main_q       <= '0;
      bubble_q     <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_q       <= main_d;
      bubble_q     <= bubble_d;
    end
  end

  assign {ctrl_r, result_out, addr_out, rnum_out, rval_out, sp_out} = main_q;

  // A bubble carries all-zero control so downstream sees a NOP
  assign ctrl_out   = ctrl_r & {CTRL_W{main_valid_q}};
  assign out_valid  = main_valid_q;
  assign fwd_valid  = main_valid_q & ctrl_r[WB_BIT];
  assign fwd_rnum   = rnum_out;
  assign fwd_value  = result_out;
  assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_em_pipe_stage.sv
// Scoreboard bench for em_pipe_stage. Honours EM_SKID_BUFFER_EN when defined.
module tb_em_pipe_stage;
  import em_pkg::*;

  localparam int unsigned CNT_W = 4;
`ifdef EM_SKID_BUFFER_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic clk, reset, in_valid, in_ready, stall, flush, out_valid, out_ready;
  logic fwd_valid;
  em_bundle_t in_b;
  logic [EM_CTRL_W-1:0] ctrl_out;
  logic [EM_DATA_W-1:0] result_out, rval_out, sp_out, fwd_value;
  logic [EM_ADDR_W-1:0] addr_out;
  logic [EM_RNUM_W-1:0] rnum_out, fwd_rnum;
  logic [CNT_W-1:0]     bubble_cnt;

  em_pipe_stage #(
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .stall      (stall),
    .flush      (flush),
    .ctrl_in    (in_b.ctrl),
    .result_in  (in_b.result),
    .addr_in    (in_b.addr),
    .rnum_in    (in_b.rnum),
    .rval_in    (in_b.rval),
    .sp_in      (in_b.sp),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ctrl_out   (ctrl_out),
    .result_out (result_out),
    .addr_out   (addr_out),
    .rnum_out   (rnum_out),
    .rval_out   (rval_out),
    .sp_out     (sp_out),
    .fwd_valid  (fwd_valid),
    .fwd_rnum   (fwd_rnum),
    .fwd_value  (fwd_value),
    .bubble_cnt (bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: bundles held by the stage, in order, plus occupancy and bubbles
  em_bundle_t exp_q[$];
  int occ = 0;
  int bub = 0;
  int n_chk = 0;
  int n_pass = 0;

  function automatic logic exp_ready();
    if (flush || stall) return 1'b0;
    if (SKID) return occ < 2;
    return (occ == 0) || out_ready;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic em_bundle_t rnd_b(input logic [15:0] res);
    em_bundle_t b;
    b.ctrl   = 7'($urandom);
    b.result = res;
    b.addr   = 16'($urandom);
    b.rnum   = 3'($urandom);
    b.rval   = 16'($urandom);
    b.sp     = 16'($urandom);
    return b;
  endfunction

  // Model update at each active edge (stimulus side pushes accepted bundles)
  initial forever begin
    @(posedge clk);
    if (!reset) begin
      occ = 0;
      bub = 0;
      exp_q.delete();
    end else begin
      logic acc;
      logic drn;
      if (occ == 0 && bub < (1 << CNT_W) - 1) bub++;
      acc = in_valid && exp_ready();
      drn = (occ > 0) && out_ready;
      if (flush) begin
        occ = 0;
        exp_q.delete();
      end else begin
        occ = occ - int'(drn) + int'(acc);
        if (acc) exp_q.push_back(in_b);
      end
    end
  end

  // Monitor: compare outputs mid-cycle, pop the scoreboard on each drain
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("out_valid", 64'(out_valid), 64'(occ > 0));
      chk("in_ready", 64'(in_ready), 64'(exp_ready()));
      chk("bubble_cnt", 64'(bubble_cnt), 64'(bub));
      if (occ == 0) begin
        chk("ctrl_bubble", 64'(ctrl_out), 64'(0));
        chk("fwd_valid_bubble", 64'(fwd_valid), 64'(0));
      end else if (exp_q.size() > 0) begin
        chk("ctrl_out", 64'(ctrl_out), 64'(exp_q[0].ctrl));
        chk("result_out", 64'(result_out), 64'(exp_q[0].result));
        chk("addr_out", 64'(addr_out), 64'(exp_q[0].addr));
        chk("rnum_out", 64'(rnum_out), 64'(exp_q[0].rnum));
        chk("rval_out", 64'(rval_out), 64'(exp_q[0].rval));
        chk("sp_out", 64'(sp_out), 64'(exp_q[0].sp));
        chk("fwd_valid", 64'(fwd_valid), 64'(exp_q[0].ctrl[0]));
        chk("fwd_rnum", 64'(fwd_rnum), 64'(exp_q[0].rnum));
        chk("fwd_value", 64'(fwd_value), 64'(exp_q[0].result));
      end
      if (out_valid === 1'b1 && out_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        else chk("drain_unexpected", 64'(1), 64'(0));
      end
    end
  end

  task automatic drive(input logic v, input logic r, input logic s, input logic f,
                       input em_bundle_t b);
    @(posedge clk);
    #1;
    in_valid  = v;
    out_ready = r;
    stall     = s;
    flush     = f;
    in_b      = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, rnd_b(16'($urandom)));
  endtask

  task automatic set_reset(input logic r);
    @(posedge clk);
    #1;
    reset = r;
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    stall     = 1'b0;
    flush     = 1'b0;
    in_b      = rnd_b(16'hDEAD);

    // Reset held with a valid input present
    drive(1'b1, 1'b1, 1'b0, 1'b0, rnd_b(16'hBEEF));
    drive(1'b1, 1'b1, 1'b0, 1'b0, rnd_b(16'hBEEF));
    set_reset(1'b1);
    in_valid = 1'b0;
    idle(1);

    // Streaming
    for (int k = 1; k <= 4; k++) drive(1'b1, 1'b1, 1'b0, 1'b0, rnd_b(16'(16'h0011 * k)));
    idle(2);

    // Backpressure
    drive(1'b1, 1'b0, 1'b0, 1'b0, rnd_b(16'hAAAA));
    drive(1'b1, 1'b0, 1'b0, 1'b0, rnd_b(16'hBBBB));
    drive(1'b1, 1'b0, 1'b0, 1'b0, in_b);
    drive(1'b1, 1'b1, 1'b0, 1'b0, in_b);
    idle(3);

    // Flush with a new bundle presented
    drive(1'b1, 1'b0, 1'b0, 1'b0, rnd_b(16'h1234));
    drive(1'b1, 1'b0, 1'b0, 1'b1, rnd_b(16'h5678));
    idle(3);

    // Stall with an entry held
    set_reset(1'b0);
    set_reset(1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, rnd_b(16'h00C3));
    drive(1'b1, 1'b1, 1'b1, 1'b0, rnd_b(16'h00C4));
    drive(1'b1, 1'b1, 1'b1, 1'b0, in_b);
    idle(2);

    // Randomised traffic with one mid-stream reset pulse
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 19) == 0),
            rnd_b(16'($urandom)));
      if (i == 200) reset = 1'b0;
      if (i == 201) reset = 1'b1;
    end
    idle(3);

    // Counter saturation
    idle(20);
    @(negedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
